// File: rtl/uart_date_rx.sv
// UART 8N1 receiver that packs eight ASCII digits "YYYYMMDD" into BCD date registers.
// Optional macro DATE_RANGE_CHK_EN rejects months outside 01..12 and days outside 01..31.
module uart_date_rx #(
    parameter int BAUD_CNT_MAX = 433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_in,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic [15:0] date_year,
    output logic [7:0]  date_month,
    output logic [7:0]  date_day,
    output logic        date_valid,
    output logic        date_err
);

    localparam logic [11:0] CNT_MAX = 12'(BAUD_CNT_MAX);
    localparam logic [11:0] HALF    = 12'(BAUD_CNT_MAX / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t      state;
    logic [11:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        rx_meta;
    logic        rx_s;

    logic [2:0]  char_cnt;
    logic [27:0] digits;
    logic [31:0] next_digits;
    logic        is_digit;
    logic        range_ok;

    // Two-flop synchronizer; idle-high reset value keeps the FSM from seeing a false start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= 12'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= 12'd0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (baud_cnt == HALF && rx_s) begin
                        state    <= IDLE;
                        baud_cnt <= 12'd0;
                    end else if (baud_cnt == CNT_MAX) begin
                        state    <= DATA;
                        bit_idx  <= 3'd0;
                        baud_cnt <= 12'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == HALF) shift[bit_idx] <= rx_s;
                    if (baud_cnt == CNT_MAX) begin
                        baud_cnt <= 12'd0;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit gives half a bit of slack to catch a back-to-back start.
                    if (baud_cnt == HALF) begin
                        baud_cnt <= 12'd0;
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else if (baud_cnt == CNT_MAX) begin
                        baud_cnt <= 12'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state    <= IDLE;
                        baud_cnt <= 12'd0;
                    end else if (baud_cnt == CNT_MAX) begin
                        baud_cnt <= 12'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= 12'd0;
                end
            endcase
        end
    end

    // The seven stored digits plus the incoming one form the full YYYYMMDD word.
    assign next_digits = {digits, rx_data[3:0]};
    assign is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);

`ifdef DATE_RANGE_CHK_EN
    assign range_ok = (next_digits[15:8] >= 8'h01) && (next_digits[15:8] <= 8'h12) &&
                      (next_digits[7:0]  >= 8'h01) && (next_digits[7:0]  <= 8'h31);
`else
    assign range_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_cnt   <= 3'd0;
            digits     <= 28'h0;
            date_year  <= 16'h0000;
            date_month <= 8'h00;
            date_day   <= 8'h00;
            date_valid <= 1'b0;
            date_err   <= 1'b0;
        end else begin
            date_valid <= 1'b0;
            date_err   <= 1'b0;
            if (frame_err) begin
                date_err <= 1'b1;
                char_cnt <= 3'd0;
            end else if (rx_valid) begin
                if (!is_digit) begin
                    date_err <= 1'b1;
                    char_cnt <= 3'd0;
                end else begin
                    digits <= next_digits[27:0];
                    if (char_cnt == 3'd7) begin
                        char_cnt <= 3'd0;
                        if (range_ok) begin
                            date_year  <= next_digits[31:16];
                            date_month <= next_digits[15:8];
                            date_day   <= next_digits[7:0];
                            date_valid <= 1'b1;
                        end else begin
                            date_err <= 1'b1;
                        end
                    end else begin
                        char_cnt <= char_cnt + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_date_rx.sv
// Bench for uart_date_rx: directed frame table, hand-written corner sequences and
// random frames checked against a digit-queue model of the date assembler.
module tb_uart_date_rx;

    localparam int BCM     = 31;
    localparam int BIT     = BCM + 1;
    localparam int LAT_NOM = 2 + 9 * BIT + BCM / 2 + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_in = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic [15:0] date_year;
    logic [7:0]  date_month;
    logic [7:0]  date_day;
    logic        date_valid;
    logic        date_err;

    always #5 clk = ~clk;

    uart_date_rx #(.BAUD_CNT_MAX(BCM)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .date_year(date_year), .date_month(date_month), .date_day(date_day),
        .date_valid(date_valid), .date_err(date_err)
    );

    typedef struct {
        logic [7:0]  data;
        logic        stopGood;
        logic        expValid;
        logic        expFerr;
        logic        expDval;
        logic        expDerr;
        logic [31:0] expDate;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int cycle = 0;
    int nValid = 0, nFerr = 0, nDval = 0, nDerr = 0, timingBad = 0, lastStrobeCycle = 0;
    logic [7:0] lastData = 8'h00;
    logic prevTrig = 1'b0, prevValid = 1'b0, prevFerr = 1'b0, prevDv = 1'b0, prevDe = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Strobe monitor: counts pulses, and flags date strobes not one clock after a byte event or wider than one clock.
    always @(negedge clk) begin
        if (rx_valid) begin
            nValid <= nValid + 1;
            lastData <= rx_data;
            lastStrobeCycle <= cycle;
        end
        if (frame_err) begin
            nFerr <= nFerr + 1;
            lastStrobeCycle <= cycle;
        end
        if (date_valid) nDval <= nDval + 1;
        if (date_err) nDerr <= nDerr + 1;
        if (((date_valid || date_err) && !prevTrig) ||
            (rx_valid && prevValid) || (frame_err && prevFerr) ||
            (date_valid && prevDv) || (date_err && prevDe))
            timingBad <= timingBad + 1;
        prevTrig  <= rx_valid || frame_err;
        prevValid <= rx_valid;
        prevFerr  <= frame_err;
        prevDv    <= date_valid;
        prevDe    <= date_err;
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic holdLine(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int snapValid, snapFerr, snapDval, snapDerr, startCycle;

    task automatic applyStimulus(input logic [7:0] b, input logic stopGood);
        snapValid  = nValid;
        snapFerr   = nFerr;
        snapDval   = nDval;
        snapDerr   = nDerr;
        startCycle = cycle;
        holdLine(1'b0, BIT);
        for (int i = 0; i < 8; i++) holdLine(b[i], BIT);
        holdLine(stopGood, BIT);
        if (!stopGood) holdLine(1'b1, BIT);
    endtask

    task automatic checkOutput(input vec_t e);
        checkVal("rx_valid_count", 32'(nValid - snapValid), 32'(e.expValid));
        if (e.expValid) checkVal("rx_data", 32'(lastData), 32'(e.data));
        checkVal("frame_err_count", 32'(nFerr - snapFerr), 32'(e.expFerr));
        checkVal("date_valid_count", 32'(nDval - snapDval), 32'(e.expDval));
        checkVal("date_err_count", 32'(nDerr - snapDerr), 32'(e.expDerr));
        checkVal("date_outputs", {date_year, date_month, date_day}, e.expDate);
        if (e.expValid || e.expFerr)
            checkRange("strobe_latency", lastStrobeCycle - startCycle, LAT_NOM, LAT_NOM + 2);
    endtask

    vec_t table_q[$];

    task automatic addVec(input logic [7:0] d, input logic sg, input logic v, input logic f,
                          input logic dv, input logic de, input logic [31:0] date);
        vec_t r;
        r.data = d; r.stopGood = sg; r.expValid = v; r.expFerr = f;
        r.expDval = dv; r.expDerr = de; r.expDate = date;
        table_q.push_back(r);
    endtask

    task automatic addDigits(input string s, input logic [31:0] held, input logic [31:0] fin,
                             input logic completes);
        for (int i = 0; i < s.len(); i++) begin
            if (completes && i == s.len() - 1) addVec(s[i], 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, fin);
            else addVec(s[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, held);
        end
    endtask

    // Reference: a queue of decimal digit values; eight of them make a date.
    int mdlQ[$];
    logic [31:0] mdlDate = 32'h0;

    task automatic modelStep(input logic [7:0] b, input logic stopGood, output vec_t e);
        logic [31:0] nd;
        int m, d;
        bit ok;
        e.data = b; e.stopGood = stopGood;
        e.expValid = 1'b0; e.expFerr = 1'b0; e.expDval = 1'b0; e.expDerr = 1'b0;
        if (!stopGood) begin
            e.expFerr = 1'b1;
            e.expDerr = 1'b1;
            mdlQ.delete();
        end else begin
            e.expValid = 1'b1;
            if (b >= 8'h30 && b <= 8'h39) begin
                mdlQ.push_back(int'(b) - 48);
                if (mdlQ.size() == 8) begin
                    nd = 32'h0;
                    for (int i = 0; i < 8; i++) nd = nd * 32'd16 + 32'(mdlQ[i]);
                    m = mdlQ[4] * 10 + mdlQ[5];
                    d = mdlQ[6] * 10 + mdlQ[7];
                    ok = 1'b1;
`ifdef DATE_RANGE_CHK_EN
                    ok = (m >= 1 && m <= 12 && d >= 1 && d <= 31);
`endif
                    if (ok) begin
                        e.expDval = 1'b1;
                        mdlDate = nd;
                    end else begin
                        e.expDerr = 1'b1;
                    end
                    mdlQ.delete();
                end
            end else begin
                e.expDerr = 1'b1;
                mdlQ.delete();
            end
        end
        e.expDate = mdlDate;
    endtask

    vec_t e;
    string s;
    logic [7:0] rb;
    logic [7:0] b;
    logic sg;
    int base, dv0, de0;

    initial begin
        addDigits("20001029", 32'h0, 32'h20001029, 1'b1);
        addVec(8'h35, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20001029);
        addVec(8'h36, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20001029);
        addDigits("2000", 32'h20001029, 32'h0, 1'b0);
        addVec(8'h41, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20001029);
        addDigits("029", 32'h20001029, 32'h0, 1'b0);
        addVec(8'h0D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20001029);
        addDigits("19991231", 32'h20001029, 32'h19991231, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_rx", 32'({rx_data, rx_valid, frame_err}), 32'h0);
        checkVal("reset_date", {date_year, date_month, date_day}, 32'h0);
        checkVal("reset_date_strobes", 32'({date_valid, date_err}), 32'h0);
        rst_n = 1'b1;
        holdLine(1'b1, BIT);

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i].data, table_q[i].stopGood);
            checkOutput(table_q[i]);
        end

        // Month 13: only the range-checked build refuses it.
        dv0 = nDval;
        de0 = nDerr;
        s = "20001329";
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
`ifdef DATE_RANGE_CHK_EN
        checkVal("range_date_valid", 32'(nDval - dv0), 32'd0);
        checkVal("range_date_err", 32'(nDerr - de0), 32'd1);
        checkVal("range_date_held", {date_year, date_month, date_day}, 32'h19991231);
        mdlDate = 32'h19991231;
`else
        checkVal("range_date_valid", 32'(nDval - dv0), 32'd1);
        checkVal("range_date_err", 32'(nDerr - de0), 32'd0);
        checkVal("range_date_new", {date_year, date_month, date_day}, 32'h20001329);
        mdlDate = 32'h20001329;
`endif
        mdlQ.delete();

        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 99) < 88) b = 8'h30 + 8'($urandom_range(0, 9));
            else b = 8'($urandom_range(0, 255));
            sg = ($urandom_range(0, 14) != 0);
            modelStep(b, sg, e);
            applyStimulus(b, sg);
            checkOutput(e);
        end

        // A low pulse shorter than half a bit must be discarded silently.
        base = nValid + nFerr + nDval + nDerr;
        holdLine(1'b0, 8);
        holdLine(1'b1, 2 * BIT);
        checkVal("glitch_no_strobes", 32'(nValid + nFerr + nDval + nDerr - base), 32'd0);
        modelStep(8'h41, 1'b1, e);
        applyStimulus(8'h41, 1'b1);
        checkOutput(e);

        // Reset in the middle of data bit 4 clears every output at once.
        rb = 8'h55;
        holdLine(1'b0, BIT);
        for (int i = 0; i < 4; i++) holdLine(rb[i], BIT);
        rx_in = rb[4];
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkVal("midreset_rx", 32'({rx_data, rx_valid, frame_err}), 32'h0);
        checkVal("midreset_date", {date_year, date_month, date_day}, 32'h0);
        checkVal("midreset_strobes", 32'({date_valid, date_err}), 32'h0);
        rx_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        holdLine(1'b1, 2 * BIT);
        mdlQ.delete();
        mdlDate = 32'h0;
        s = "20001029";
        for (int i = 0; i < s.len(); i++) begin
            modelStep(s[i], 1'b1, e);
            applyStimulus(s[i], 1'b1);
            checkOutput(e);
        end
        checkVal("post_reset_date", {date_year, date_month, date_day}, 32'h20001029);

        holdLine(1'b1, 4);
        checkVal("strobe_timing", 32'(timingBad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
